// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown timer control core: state encoding,
// BCD digit width and the mod-60 digit limits.
package countdown_ctrl_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MOD60_MAX_TENS = 4'd5;
  localparam logic [DIGIT_W-1:0] MOD60_MAX_ONES = 4'd9;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SET_MIN = 3'd1;
  localparam logic [2:0] ST_SET_SEC = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;
  localparam logic [2:0] ST_ALARM   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SET_MIN = ST_SET_MIN,
    S_SET_SEC = ST_SET_SEC,
    S_RUN     = ST_RUN,
    S_PAUSE   = ST_PAUSE,
    S_ALARM   = ST_ALARM
  } state_t;

endpackage

// File: rtl/countdown_ctrl_mod60_bcd_cnt.sv
// Two-digit BCD up/down counter over 00..59 with wrap in both directions.
// BORROW flags a decrement request at 00 so a higher-order counter can follow.
module mod60_bcd_cnt
  import countdown_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               INC,
  input  logic               DEC,
  output logic [DIGIT_W-1:0] TENS,
  output logic [DIGIT_W-1:0] ONES,
  output logic               BORROW
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;

  // Next digit values; INC takes precedence if both requests arrive together.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (INC) begin
      if (ones_q == MOD60_MAX_ONES) begin
        ones_d = '0;
        tens_d = (tens_q == MOD60_MAX_TENS) ? '0 : tens_q + 1'b1;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end else if (DEC) begin
      if (ones_q == '0) begin
        ones_d = MOD60_MAX_ONES;
        tens_d = (tens_q == '0) ? MOD60_MAX_TENS : tens_q - 1'b1;
      end else begin
        ones_d = ones_q - 1'b1;
      end
    end
  end

  // Digit registers, held while CE is low.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      tens_q <= '0;
      ones_q <= '0;
    end else if (CE) begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign TENS   = tens_q;
  assign ONES   = ones_q;
  assign BORROW = DEC & ~INC & (tens_q == '0) & (ones_q == '0);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer control core: key-driven MM:SS setting, 1 Hz countdown,
// timed alarm, and the auto-repeat enable for the UP/DOWN debouncers.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int ALARM_TICKS    = 10,
  parameter int ALARM_CNT_BITS = 8
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               TICK_1HZ,
  input  logic               KEY_MODE,
  input  logic               KEY_UP,
  input  logic               KEY_DOWN,
  input  logic               KEY_START,
  output logic [DIGIT_W-1:0] MIN_TENS,
  output logic [DIGIT_W-1:0] MIN_ONES,
  output logic [DIGIT_W-1:0] SEC_TENS,
  output logic [DIGIT_W-1:0] SEC_ONES,
  output logic               EDIT_MIN,
  output logic               EDIT_SEC,
  output logic               RUNNING,
  output logic               ALARM,
  output logic               REP_EN
);

  localparam logic [ALARM_CNT_BITS-1:0] ALARM_LOAD = ALARM_CNT_BITS'(ALARM_TICKS - 1);

  state_t                    state_q, state_d;
  logic [ALARM_CNT_BITS-1:0] alarm_cnt_q, alarm_cnt_d;

  // Keys resolved by priority START > MODE > UP > DOWN.
  logic start_k, mode_k, up_k, dn_k, any_key;
  assign start_k = KEY_START;
  assign mode_k  = KEY_MODE & ~KEY_START;
  assign up_k    = KEY_UP   & ~KEY_MODE & ~KEY_START;
  assign dn_k    = KEY_DOWN & ~KEY_UP & ~KEY_MODE & ~KEY_START;
  assign any_key = KEY_START | KEY_MODE | KEY_UP | KEY_DOWN;

  // A tick in RUN only counts when no key arrives in the same cycle.
  logic run_tick;
  assign run_tick = (state_q == S_RUN) & TICK_1HZ & ~any_key;

  logic sec_inc, sec_dec, min_inc, min_dec, sec_borrow, min_borrow_unused;
  assign sec_inc = (state_q == S_SET_SEC) & up_k;
  assign sec_dec = ((state_q == S_SET_SEC) & dn_k) | run_tick;
  assign min_inc = (state_q == S_SET_MIN) & up_k;
  // Seconds borrow feeds minutes only while counting, never while editing.
  assign min_dec = ((state_q == S_SET_MIN) & dn_k) | (run_tick & sec_borrow);

  mod60_bcd_cnt u_sec (
    .CLK    (CLK),
    .CLR    (CLR),
    .CE     (CE),
    .INC    (sec_inc),
    .DEC    (sec_dec),
    .TENS   (SEC_TENS),
    .ONES   (SEC_ONES),
    .BORROW (sec_borrow)
  );

  mod60_bcd_cnt u_min (
    .CLK    (CLK),
    .CLR    (CLR),
    .CE     (CE),
    .INC    (min_inc),
    .DEC    (min_dec),
    .TENS   (MIN_TENS),
    .ONES   (MIN_ONES),
    .BORROW (min_borrow_unused)
  );

  logic time_zero, time_one;
  assign time_zero = (MIN_TENS == '0) & (MIN_ONES == '0) & (SEC_TENS == '0) & (SEC_ONES == '0);
  assign time_one  = (MIN_TENS == '0) & (MIN_ONES == '0) & (SEC_TENS == '0) & (SEC_ONES == 4'd1);

  // Next-state and alarm duration counter decode.
  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_k) begin
          if (!time_zero) state_d = S_RUN;
        end else if (mode_k) begin
          state_d = S_SET_MIN;
        end
      end
      S_SET_MIN: begin
        if (start_k)     state_d = time_zero ? S_IDLE : S_RUN;
        else if (mode_k) state_d = S_SET_SEC;
      end
      S_SET_SEC: begin
        if (start_k)     state_d = time_zero ? S_IDLE : S_RUN;
        else if (mode_k) state_d = S_IDLE;
      end
      S_RUN: begin
        if (start_k) begin
          state_d = S_PAUSE;
        end else if (run_tick && time_one) begin
          state_d     = S_ALARM;
          alarm_cnt_d = ALARM_LOAD;
        end
      end
      S_PAUSE: begin
        if (start_k)     state_d = S_RUN;
        else if (mode_k) state_d = S_IDLE;
      end
      S_ALARM: begin
        if (any_key) begin
          state_d = S_IDLE;
        end else if (TICK_1HZ) begin
          if (alarm_cnt_q == '0) state_d = S_IDLE;
          else                   alarm_cnt_d = alarm_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and alarm counter registers; CLR wins over CE.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= S_IDLE;
      alarm_cnt_q <= '0;
    end else if (CE) begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign EDIT_MIN = (state_q == S_SET_MIN);
  assign EDIT_SEC = (state_q == S_SET_SEC);
  assign RUNNING  = (state_q == S_RUN);
  assign ALARM    = (state_q == S_ALARM);
  assign REP_EN   = (state_q == S_SET_MIN) | (state_q == S_SET_SEC);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: vector table, hand sequences for multi-cycle
// corners, then random stimulus against a seconds-level behavioural model.
module tb_countdown_ctrl;

  localparam int AT = 3;

  logic       CLK = 1'b0;
  logic       CLR, CE, TICK_1HZ, KEY_MODE, KEY_UP, KEY_DOWN, KEY_START;
  logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
  logic       EDIT_MIN, EDIT_SEC, RUNNING, ALARM, REP_EN;

  countdown_ctrl #(.ALARM_TICKS(AT), .ALARM_CNT_BITS(8)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .TICK_1HZ(TICK_1HZ),
    .KEY_MODE(KEY_MODE), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_START(KEY_START),
    .MIN_TENS(MIN_TENS), .MIN_ONES(MIN_ONES), .SEC_TENS(SEC_TENS), .SEC_ONES(SEC_ONES),
    .EDIT_MIN(EDIT_MIN), .EDIT_SEC(EDIT_SEC), .RUNNING(RUNNING), .ALARM(ALARM), .REP_EN(REP_EN)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Behavioural model: time held as plain minute/second integers.
  typedef enum int {M_IDLE, M_SMIN, M_SSEC, M_RUN, M_PAUSE, M_ALARM} mst_t;
  mst_t m_st;
  int   m_min, m_sec, m_acnt;

  task automatic model_step(input bit clr, ce, tick, mode, up, down, start);
    int  t;
    bit  anykey;
    if (clr) begin
      m_st = M_IDLE; m_min = 0; m_sec = 0; m_acnt = 0;
      return;
    end
    if (!ce) return;
    anykey = mode | up | down | start;
    t = m_min * 60 + m_sec;
    case (m_st)
      M_IDLE:  if (start) begin if (t != 0) m_st = M_RUN; end
               else if (mode) m_st = M_SMIN;
      M_SMIN:  if (start) m_st = (t != 0) ? M_RUN : M_IDLE;
               else if (mode) m_st = M_SSEC;
               else if (up)   m_min = (m_min + 1) % 60;
               else if (down) m_min = (m_min + 59) % 60;
      M_SSEC:  if (start) m_st = (t != 0) ? M_RUN : M_IDLE;
               else if (mode) m_st = M_IDLE;
               else if (up)   m_sec = (m_sec + 1) % 60;
               else if (down) m_sec = (m_sec + 59) % 60;
      M_RUN:   if (start) m_st = M_PAUSE;
               else if (!anykey && tick) begin
                 t = t - 1;
                 m_min = t / 60; m_sec = t % 60;
                 if (t == 0) begin m_st = M_ALARM; m_acnt = AT - 1; end
               end
      M_PAUSE: if (start) m_st = M_RUN;
               else if (mode) m_st = M_IDLE;
      M_ALARM: if (anykey) m_st = M_IDLE;
               else if (tick) begin
                 if (m_acnt == 0) m_st = M_IDLE;
                 else m_acnt = m_acnt - 1;
               end
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic logic [15:0] dut_time();
    return {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
  endfunction

  function automatic logic [4:0] dut_flags();
    return {EDIT_MIN, EDIT_SEC, RUNNING, ALARM, REP_EN};
  endfunction

  function automatic logic [15:0] mdl_time();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic logic [4:0] mdl_flags();
    return {m_st == M_SMIN, m_st == M_SSEC, m_st == M_RUN, m_st == M_ALARM,
            (m_st == M_SMIN) || (m_st == M_SSEC)};
  endfunction

  // One clock with the given inputs; outputs compared to the model 1 time unit later.
  task automatic cyc(input bit clr, ce, tick, mode, up, down, start);
    CLR = clr; CE = ce; TICK_1HZ = tick;
    KEY_MODE = mode; KEY_UP = up; KEY_DOWN = down; KEY_START = start;
    @(posedge CLK);
    model_step(clr, ce, tick, mode, up, down, start);
    #1;
    CLR = 1'b0; CE = 1'b1; TICK_1HZ = 1'b0;
    KEY_MODE = 1'b0; KEY_UP = 1'b0; KEY_DOWN = 1'b0; KEY_START = 1'b0;
    ncyc++;
    total++;
    if ({dut_time(), dut_flags()} !== {mdl_time(), mdl_flags()}) begin
      bad++;
      $display("FAIL model cyc=%0d got t=%h f=%b want t=%h f=%b",
               ncyc, dut_time(), dut_flags(), mdl_time(), mdl_flags());
    end
  endtask

  task automatic expect_out(input string nm, input logic [15:0] t, input logic [4:0] f);
    total++;
    if (dut_time() !== t || dut_flags() !== f) begin
      bad++;
      $display("FAIL %s got t=%h f=%b want t=%h f=%b", nm, dut_time(), dut_flags(), t, f);
    end
  endtask

  task automatic k_mode();  cyc(0, 1, 0, 1, 0, 0, 0); endtask
  task automatic k_up();    cyc(0, 1, 0, 0, 1, 0, 0); endtask
  task automatic k_start(); cyc(0, 1, 0, 0, 0, 0, 1); endtask
  task automatic tick();    cyc(0, 1, 1, 0, 0, 0, 0); endtask
  task automatic idle();    cyc(0, 1, 0, 0, 0, 0, 0); endtask

  typedef struct {
    bit         clr, ce, tick, mode, up, down, start;
    logic [15:0] t;
    logic [4:0]  f;
  } vec_t;

  function automatic vec_t mk(bit clr, ce, tick, mode, up, down, start,
                              logic [15:0] t, logic [4:0] f);
    vec_t v;
    v.clr = clr; v.ce = ce; v.tick = tick; v.mode = mode;
    v.up = up; v.down = down; v.start = start; v.t = t; v.f = f;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    // flags order: EDIT_MIN EDIT_SEC RUNNING ALARM REP_EN
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);
    vecs[1]  = mk(0, 1, 0, 1, 0, 0, 0, 16'h0000, 5'b10001);
    vecs[2]  = mk(0, 1, 0, 0, 1, 0, 0, 16'h0100, 5'b10001);
    vecs[3]  = mk(0, 1, 0, 0, 1, 0, 0, 16'h0200, 5'b10001);
    vecs[4]  = mk(0, 1, 0, 0, 1, 0, 0, 16'h0300, 5'b10001);
    vecs[5]  = mk(0, 1, 0, 1, 0, 0, 0, 16'h0300, 5'b01001);
    vecs[6]  = mk(0, 1, 0, 0, 0, 1, 0, 16'h0359, 5'b01001);
    vecs[7]  = mk(0, 1, 0, 1, 0, 0, 0, 16'h0359, 5'b00000);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 1, 16'h0000, 5'b00000);
    vecs[10] = mk(0, 1, 0, 1, 0, 0, 0, 16'h0000, 5'b10001);
    vecs[11] = mk(0, 1, 0, 0, 0, 1, 0, 16'h5900, 5'b10001);
    vecs[12] = mk(0, 1, 0, 0, 1, 0, 0, 16'h0000, 5'b10001);
    vecs[13] = mk(0, 1, 0, 0, 1, 1, 0, 16'h0100, 5'b10001);
    vecs[14] = mk(0, 1, 0, 1, 1, 0, 0, 16'h0100, 5'b01001);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 16'h0100, 5'b01001);
    vecs[16] = mk(0, 1, 0, 0, 0, 1, 0, 16'h0159, 5'b01001);
    vecs[17] = mk(0, 1, 0, 0, 1, 0, 0, 16'h0100, 5'b01001);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 1, 16'h0100, 5'b00100);
    vecs[19] = mk(0, 1, 1, 0, 0, 0, 0, 16'h0059, 5'b00100);

    CLR = 1'b1; CE = 1'b1; TICK_1HZ = 1'b0;
    KEY_MODE = 1'b0; KEY_UP = 1'b0; KEY_DOWN = 1'b0; KEY_START = 1'b0;
    m_st = M_IDLE; m_min = 0; m_sec = 0; m_acnt = 0;

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].clr, vecs[i].ce, vecs[i].tick, vecs[i].mode,
          vecs[i].up, vecs[i].down, vecs[i].start);
      total++;
      if (dut_time() !== vecs[i].t || dut_flags() !== vecs[i].f) begin
        bad++;
        $display("FAIL vec[%0d] got t=%h f=%b want t=%h f=%b",
                 i, dut_time(), dut_flags(), vecs[i].t, vecs[i].f);
      end
    end

    // Count the rest of the minute down into the alarm.
    repeat (58) tick();
    expect_out("run_0001", 16'h0001, 5'b00100);
    tick();
    expect_out("alarm_entry", 16'h0000, 5'b00010);
    idle();
    tick();
    idle();
    tick();
    idle();
    expect_out("alarm_after2", 16'h0000, 5'b00010);
    tick();
    expect_out("alarm_after3", 16'h0000, 5'b00000);

    // START and TICK together at 00:01, resume, then key out of the alarm.
    k_mode(); k_mode(); k_up(); k_start();
    expect_out("run_at_0001", 16'h0001, 5'b00100);
    cyc(0, 1, 1, 0, 0, 0, 1);
    expect_out("pause_hold", 16'h0001, 5'b00000);
    k_start();
    expect_out("resume", 16'h0001, 5'b00100);
    tick();
    expect_out("alarm2", 16'h0000, 5'b00010);
    k_up();
    expect_out("alarm_key_exit", 16'h0000, 5'b00000);

    // CLR in the middle of a 12:34 run, with CE low to show CLR wins.
    k_mode();
    repeat (12) k_up();
    k_mode();
    repeat (34) k_up();
    k_start();
    expect_out("run_1234", 16'h1234, 5'b00100);
    tick();
    expect_out("run_1233", 16'h1233, 5'b00100);
    cyc(1, 0, 1, 0, 0, 0, 0);
    expect_out("clr_mid_run", 16'h0000, 5'b00000);

    // CE low swallows a tick.
    k_mode(); k_mode();
    repeat (5) k_up();
    k_start();
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("ce_low_tick", 16'h0005, 5'b00100);
    tick();
    expect_out("ce_high_tick", 16'h0004, 5'b00100);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 13) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
